// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: NOP constant, stage state encoding, entry bundle.
package pipe_pkg;

  localparam int PKG_ADDR_W  = 64;
  localparam int PKG_INSTR_W = 32;

  localparam logic [PKG_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0]  pc;
    logic [PKG_INSTR_W-1:0] instr;
    logic                   pred_taken;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Valid/ready handshake carrying one IF/ID entry.
interface if_id_skid_reg_if;
  import pipe_pkg::*;

  logic         valid;
  logic         ready;
  if_id_entry_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_entry_reg.sv
// Async-reset entry register; invalid or cleared slots hold the NOP payload.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter if_id_entry_t NOP_E = '{pc: '0, instr: NOP_INSTR, pred_taken: 1'b0}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_vld,
  input  if_id_entry_t i_d,
  output if_id_entry_t o_q,
  output logic         o_vld
);

  if_id_entry_t r_q;
  logic         r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= NOP_E;
      r_vld <= 1'b0;
    end else if (i_clr) begin
      r_q   <= NOP_E;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_q   <= i_vld ? i_d : NOP_E;
      r_vld <= i_vld;
    end
  end

  assign o_q   = r_q;
  assign o_vld = r_vld;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with flush and NOP fill.
// Define IF_ID_SKID_EN for the two-entry skid buffer with registered in_ready.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 ADDR_W    = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  if_id_skid_reg_if.slave         in_if,
  if_id_skid_reg_if.master        out_if,
  output logic [1:0]              occupancy
);

  localparam logic [ADDR_W-1:0]  NOP_PC = '0;
  localparam if_id_entry_t       NOP_E  = '{
    pc: NOP_PC, instr: NOP_INSTR, pred_taken: 1'b0};

  state_e       r_state;
  state_e       w_nxt;
  logic         w_in_rdy;
  logic         w_fire_in;
  logic         w_fire_out;
  logic         w_m_ld;
  logic         w_m_vld;
  if_id_entry_t w_m_d;
  if_id_entry_t w_m_q;
  logic         w_m_q_vld;

  assign w_fire_in  = in_if.valid && w_in_rdy;
  assign w_fire_out = w_m_q_vld && out_if.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_fire_in) w_nxt = ST_FULL;
      ST_FULL: begin
`ifdef IF_ID_SKID_EN
        if (w_fire_in && !w_fire_out)      w_nxt = ST_SKID;
        else if (!w_fire_in && w_fire_out) w_nxt = ST_EMPTY;
`else
        if (!w_fire_in && w_fire_out)      w_nxt = ST_EMPTY;
`endif
      end
`ifdef IF_ID_SKID_EN
      ST_SKID:  if (w_fire_out) w_nxt = ST_FULL;
`endif
      default:  w_nxt = ST_EMPTY;
    endcase
    if (flush) w_nxt = ST_EMPTY;
  end

`ifdef IF_ID_SKID_EN
  logic         r_in_rdy;
  logic         w_s_ld;
  logic         w_s_vld;
  if_id_entry_t w_s_q;
  logic         w_s_q_vld;

  // Ready is a flop so fetch never sees a path from decode's ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_rdy <= 1'b1;
    else        r_in_rdy <= (w_nxt != ST_SKID);
  end

  assign w_in_rdy = r_in_rdy;

  pipe_entry_reg #(.NOP_E(NOP_E)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (flush),
    .i_load (w_s_ld),
    .i_vld  (w_s_vld),
    .i_d    (in_if.data),
    .o_q    (w_s_q),
    .o_vld  (w_s_q_vld)
  );
`else
  assign w_in_rdy = !w_m_q_vld || out_if.ready;
`endif

  always_comb begin
    w_m_ld  = 1'b0;
    w_m_vld = 1'b0;
    w_m_d   = in_if.data;
`ifdef IF_ID_SKID_EN
    w_s_ld  = 1'b0;
    w_s_vld = 1'b0;
`endif
    unique case (1'b1)
      (r_state == ST_EMPTY): begin
        w_m_ld  = w_fire_in;
        w_m_vld = 1'b1;
      end
      (r_state == ST_FULL): begin
        if (w_fire_out) begin
          w_m_ld  = 1'b1;
          w_m_vld = w_fire_in;
        end
`ifdef IF_ID_SKID_EN
        else if (w_fire_in) begin
          w_s_ld  = 1'b1;
          w_s_vld = 1'b1;
        end
`endif
      end
`ifdef IF_ID_SKID_EN
      (r_state == ST_SKID): begin
        if (w_fire_out) begin
          w_m_ld  = 1'b1;
          w_m_d   = w_s_q;
          w_m_vld = w_s_q_vld;
          w_s_ld  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  pipe_entry_reg #(.NOP_E(NOP_E)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (flush),
    .i_load (w_m_ld),
    .i_vld  (w_m_vld),
    .i_d    (w_m_d),
    .o_q    (w_m_q),
    .o_vld  (w_m_q_vld)
  );

  assign in_if.ready  = w_in_rdy;
  assign out_if.valid = w_m_q_vld;
  assign out_if.data  = w_m_q;

  assign occupancy = (r_state == ST_SKID) ? 2'd2 :
                     (r_state == ST_FULL) ? 2'd1 : 2'd0;

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between instruction fetch and decode and replaces the plain write-enable/flush latch. It carries PC, instruction and a predicted-taken bit. Stalls become backpressure, and flushed slots are refilled with a canonical NOP rather than undefined data.

## Interface
- `ADDR_W`, 64, PC width in bits.
- `INSTR_W`, 32, instruction width in bits.
- `NOP_INSTR`, 32'h0000_0013, instruction driven when a slot is empty or flushed (`addi x0,x0,0`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush (branch mispredict or redirect).
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  stage can accept; transfer when `in_valid && in_ready`.
- `in_pc`  in  ADDR_W  PC of the fetched instruction.
- `in_instr`  in  INSTR_W  fetched instruction.
- `in_pred_taken`  in  1  fetch-side branch prediction.
- `out_valid`  out  1  decode entry valid.
- `out_ready`  in  1  decode accepts; stall = `out_ready` low.
- `out_pc`  out  ADDR_W  registered PC.
- `out_instr`  out  INSTR_W  registered instruction.
- `out_pred_taken`  out  1  registered prediction.
- `occupancy`  out  2  entries held (0–2).

## Operation
- Entry = {pc, instr, pred_taken}. There is a main register, which drives the outputs, and a skid register.
- Each stored entry has its own valid flag. `out_valid` is the main register's valid flag.
- State machine (skid mode):
  - EMPTY: on an in-fire, load main and go to FULL.
  - FULL, in-fire and out-fire: reload main and stay in FULL.
  - FULL, in-fire without out-fire: write the skid register and go to SKID.
  - FULL, out-fire without in-fire: go to EMPTY.
  - SKID: `in_ready`=0. On an out-fire, main takes the skid contents and the state goes to FULL.
- `flush` has priority over everything else:
  - Next state is EMPTY and both valid flags clear.
  - Main payload becomes pc=0, instr=`NOP_INSTR`, pred_taken=0.
  - An in-fire in the same cycle is discarded. Upstream treats it as consumed, because fetch is redirected in the same cycle.
- Whenever `out_valid`=0, outputs are held at NOP payload. No X is ever driven.
- `occupancy`: 0 in EMPTY, 1 in FULL, 2 in SKID.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset values: `out_valid`=0, `out_pc`=0, `out_instr`=`NOP_INSTR`, `out_pred_taken`=0, `occupancy`=0, `in_ready`=1, state EMPTY.
- Latency: 1 cycle from in-fire to `out_valid` when the stage is empty.
- Throughput: 1 entry per cycle while `out_ready`=1.
- Skid mode: `in_ready` is a register output (high in EMPTY and FULL, low in SKID). It has no combinational path from `out_ready`.
- A single stall cycle in FULL absorbs at most one extra entry. A second stall cycle keeps `in_ready`=0.
- Flush in SKID with `out_ready`=1: the flush wins, and the out-fire in that cycle still counts as consumed downstream.
- `rst_n` asserted mid-stream clears all state immediately, without waiting for a clock edge.
- `out_*` must not change while `out_valid && !out_ready`.

## Configuration
- `IF_ID_SKID_EN` defined: two-entry skid buffer with registered `in_ready`, as described above.
- Undefined: main register only.
  - `in_ready = !out_valid || out_ready`, a combinational path.
  - `occupancy` never exceeds 1.
  - SKID state and skid register are absent.
  - Flush, reset and NOP-fill behaviour are identical to skid mode.

## Structure
- Shared package `pipe_pkg` holds:
  - the `NOP_INSTR` constant;
  - the state encoding (EMPTY/FULL/SKID);
  - the `if_id_entry_t` packed struct {pc, instr, pred_taken}, widths taken from the package defaults.
- One sub-module, `pipe_entry_reg`: an asynchronously reset entry register with load enable and NOP-clear. It is instantiated for main and, if enabled, for skid.

## Test plan
- Reset: release `rst_n` → `out_valid`=0, `out_instr`=32'h00000013, `in_ready`=1, `occupancy`=0.
- Streaming: PCs 0x0, 0x4, 0x8 with `out_ready`=1 → same sequence appears on `out_pc`, 1 cycle later, with no bubbles.
- Stall, skid enabled: `out_ready`=0 for 3 cycles while PCs 0x10, 0x14, 0x18 are offered →
  - `occupancy` reaches 2 and `in_ready` drops after 2 acceptances;
  - 0x18 is held at the input;
  - after release, 0x10, 0x14, 0x18 drain in order.
- Flush in SKID: flush asserted with 2 entries held and `in_valid`=1 → next cycle `out_valid`=0, `out_instr`=NOP, `occupancy`=0, `in_ready`=1; the in-flight entry is not seen.
- Async reset mid-stall: `rst_n` low between edges → outputs reach reset values before the next `clk` edge.
- Skid disabled: same stall stimulus → `in_ready` follows `out_ready` combinationally whenever `out_valid`=1; `occupancy` never exceeds 1.
